rr_mux_scheduler: RTL
=====================

Name: rr_mux_scheduler

Overview:
- Shares one 8-bit output channel among three requesters (alpha, beta, gamma) using round-robin arbitration with bounded bursts.
- Drives a registered valid/ready output stage.
- Reports the current owner with the same select encoding the team's asynchronous mux/decoder uses: 00 alpha, 01 beta, 10 gamma, plus a chip-select style busy flag.
- Sits between the three data producers and a single downstream consumer.

Parameters:
- W, 8, data width of each requester and of the output.
- BURST_MAX, 4, maximum beats accepted from one owner per grant; legal range 1..15.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  3  per-requester beat-available; bit0 alpha, bit1 beta, bit2 gamma.
- alpha  input  W  requester 0 data; stable while req[0]=1 and ack[0]=0.
- beta  input  W  requester 1 data.
- gamma  input  W  requester 2 data.
- ack  output  3  one-hot, combinational; ack[i]=1 in the cycle requester i's beat is captured.
- out  output  W  registered output data.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  downstream accepts the beat when out_valid=1.
- sel  output  2  current owner encoding (00/01/10); 00 when idle.
- cs  output  1  1 while in GRANT state.

Behaviour:
- Reset (synchronous, active-high), effective at the next rising edge:
  - state=IDLE, owner=0, last=2 (alpha has top priority first), beat count=0.
  - out=0, out_valid=0, sel=00, cs=0, ack=000.
  - A beat held in the output register is dropped.
  - Reset asserted mid-burst aborts the burst; no ack is issued in that cycle.
- IDLE state:
  - If req is nonzero, pick the first set bit searching from (last+1) mod 3 upward with wrap.
  - Next state GRANT, owner=pick, count=0.
  - No ack and no load in IDLE, so every grant change costs exactly one bubble cycle.
  - If req=000, remain in IDLE.
- GRANT state:
  - load = req[owner] && (!out_valid || out_ready).
  - ack[owner] = load. All other ack bits are always 0.
  - On load: out<=selected data, out_valid<=1, count<=count+1.
  - If load and count==BURST_MAX-1: next state IDLE, last<=owner, burst ends after exactly BURST_MAX beats.
  - If req[owner]=0: next state IDLE, last<=owner, no load. An owner dropping req forfeits the rest of its burst.
  - Otherwise stay in GRANT with the same owner; stalls via out_ready=0 do not consume count.
- Output register:
  - If out_valid && out_ready && !load: out_valid<=0; out keeps its last value.
  - If out_valid && out_ready && load: new beat replaces the old in the same cycle, giving full throughput of 1 beat/cycle within a burst.
  - If out_valid && !out_ready: out and out_valid hold, and load=0.
- sel/cs:
  - Registered from state: cs=(state==GRANT); sel=owner in GRANT, else 00.
  - The value 11 is never driven.
- Fairness:
  - With all three requesting continuously, grant order is alpha, beta, gamma, alpha, …
  - Each grant lasts BURST_MAX beats, followed by a 1-cycle IDLE gap.
- Latency: a beat acked in cycle N appears on out with out_valid=1 in cycle N+1.
- BURST_MAX=1: ownership rotates after every beat.

Test Plan:
- Reset, then req=001, alpha=0x11, out_ready=1 held → ack[0] in cycle 2 (IDLE then GRANT), out=0x11 valid cycle 3; sel=00, cs=1; the 4th ack returns the block to IDLE.
- req=111 held, out_ready=1, BURST_MAX=4 → ack pattern 4×alpha, gap, 4×beta, gap, 4×gamma, gap, alpha; sel steps 00→01→10.
- Owner beta, out_ready=0 for 3 cycles after first beat → out/out_valid hold value (e.g. 0x22), ack=000, count unchanged; on out_ready=1 the remaining 3 beats flow back-to-back.
- Owner gamma drops req after 2 beats while alpha requests → IDLE one cycle, then alpha granted; gamma's next request waits for beta/alpha rotation per pointer last=2.
- Assert reset mid-burst with out_valid=1, out=0x33 → next cycle out=0, out_valid=0, cs=0, sel=00; after release with req=110, beta is granted first.
- BURST_MAX=1, req=101 → grants alternate alpha, gamma, alpha, with one IDLE cycle between each beat.

Source files
------------

// File: rtl/rr_mux_scheduler.sv
// Round-robin scheduler sharing one registered valid/ready output among
// three requesters (alpha, beta, gamma) with bursts of at most BURST_MAX beats.
module rr_mux_scheduler #(
  parameter int W         = 8,
  parameter int BURST_MAX = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [2:0]   req,
  input  logic [W-1:0] alpha,
  input  logic [W-1:0] beta,
  input  logic [W-1:0] gamma,
  output logic [2:0]   ack,
  output logic [W-1:0] out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   sel,
  output logic         cs
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [3:0] BURST_LAST = 4'(BURST_MAX - 1);

  state_t       state_r, state_s;
  logic [1:0]   owner_r, owner_s;
  logic [1:0]   last_r, last_s;
  logic [3:0]   count_r, count_s;
  logic [W-1:0] out_r;
  logic         out_valid_r;
  logic [1:0]   sel_r;
  logic         cs_r;
  logic         load_s;
  logic         own_req_s;
  logic [W-1:0] data_s;
  logic [2:0]   ack_s;

  // First requester found searching upward from the one after the last owner.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] l);
    logic [1:0] p0, p1, p2;
    case (l)
      2'd0:    begin p0 = 2'd1; p1 = 2'd2; p2 = 2'd0; end
      2'd1:    begin p0 = 2'd2; p1 = 2'd0; p2 = 2'd1; end
      default: begin p0 = 2'd0; p1 = 2'd1; p2 = 2'd2; end
    endcase
    if (r[p0]) begin
      rr_pick = p0;
    end else if (r[p1]) begin
      rr_pick = p1;
    end else begin
      rr_pick = p2;
    end
  endfunction

  // Owner-indexed request bit, data mux and one-hot acknowledge.
  always_comb begin
    own_req_s = 1'b0;
    data_s    = gamma;
    ack_s     = 3'b000;
    case (owner_r)
      2'd0:    begin own_req_s = req[0]; data_s = alpha; ack_s = 3'b001; end
      2'd1:    begin own_req_s = req[1]; data_s = beta;  ack_s = 3'b010; end
      2'd2:    begin own_req_s = req[2]; data_s = gamma; ack_s = 3'b100; end
      default: begin own_req_s = 1'b0;   data_s = gamma; ack_s = 3'b000; end
    endcase
  end

  // Next-state, burst counting and load decision.
  always_comb begin
    state_s = state_r;
    owner_s = owner_r;
    last_s  = last_r;
    count_s = count_r;
    load_s  = 1'b0;
    ack     = 3'b000;
    case (state_r)
      IDLE: begin
        if (req != 3'b000) begin
          state_s = GRANT;
          owner_s = rr_pick(req, last_r);
          count_s = 4'd0;
        end else begin
          state_s = IDLE;
        end
      end
      GRANT: begin
        // Reset suppresses the beat so an aborted burst never acks.
        load_s = own_req_s && (!out_valid_r || out_ready) && !reset;
        if (load_s) begin
          ack     = ack_s;
          count_s = count_r + 4'd1;
          if (count_r == BURST_LAST) begin
            state_s = IDLE;
            last_s  = owner_r;
          end else begin
            state_s = GRANT;
          end
        end else if (!own_req_s) begin
          state_s = IDLE;
          last_s  = owner_r;
        end else begin
          state_s = GRANT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, output register and registered owner indication.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      owner_r     <= 2'd0;
      last_r      <= 2'd2;
      count_r     <= 4'd0;
      out_r       <= '0;
      out_valid_r <= 1'b0;
      sel_r       <= 2'b00;
      cs_r        <= 1'b0;
    end else begin
      state_r <= state_s;
      owner_r <= owner_s;
      last_r  <= last_s;
      count_r <= count_s;
      if (load_s) begin
        out_r       <= data_s;
        out_valid_r <= 1'b1;
      end else if (out_valid_r && out_ready) begin
        out_valid_r <= 1'b0;
      end
      cs_r  <= (state_s == GRANT);
      sel_r <= (state_s == GRANT) ? owner_s : 2'b00;
    end
  end

  assign out       = out_r;
  assign out_valid = out_valid_r;
  assign sel       = sel_r;
  assign cs        = cs_r;

endmodule
